// File: rtl/bcpu_defs.sv
// ---------------------------------------------------------------------------
// bcpu_defs
// Shared BCPU definitions.
//   bus_wr_op_t : 2-bit OBUS/IBUS write-operation code (WRITE/SET/RESET/INVERT)
//   obus_req_t  : one OBUS write request (op, addr, data, mask), sized at the
//                 largest supported address/data widths; users zero-extend into
//                 it and truncate back out.
//   obus_apply  : read-modify-write of one register value by one operation.
// ---------------------------------------------------------------------------
package bcpu_defs;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'd0,
        OP_SET    = 2'd1,
        OP_RESET  = 2'd2,
        OP_INVERT = 2'd3
    } bus_wr_op_t;

    // Upper bounds on the OBUS address/data widths carried by obus_req_t.
    localparam int OBUS_ADDR_MAX = 8;
    localparam int OBUS_DATA_MAX = 32;

    typedef struct packed {
        bus_wr_op_t               op;
        logic [OBUS_ADDR_MAX-1:0] addr;
        logic [OBUS_DATA_MAX-1:0] data;
        logic [OBUS_DATA_MAX-1:0] mask;
    } obus_req_t;

    // Purely bitwise, so evaluating at the maximum width and truncating gives
    // the same result as evaluating at any narrower width.
    function automatic logic [OBUS_DATA_MAX-1:0] obus_apply(
        input bus_wr_op_t               op,
        input logic [OBUS_DATA_MAX-1:0] old_v,
        input logic [OBUS_DATA_MAX-1:0] data_v,
        input logic [OBUS_DATA_MAX-1:0] mask_v
    );
        logic [OBUS_DATA_MAX-1:0] res;
        case (op)
            OP_WRITE:  res = (old_v & ~mask_v) | (data_v & mask_v);
            OP_SET:    res = old_v | mask_v;
            OP_RESET:  res = old_v & ~mask_v;
            default:   res = old_v ^ mask_v;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bcpu_rr_arbiter.sv
// ---------------------------------------------------------------------------
// bcpu_rr_arbiter
// Round-robin arbiter over N requesters. The scan starts at the internal
// pointer and wraps modulo N; the first active request wins. After a grant to
// g the pointer moves to (g+1) mod N; with no requests it holds.
//   i_clk        : clock
//   i_rst_n      : asynchronous active-low reset (pointer -> 0)
//   i_req        : request vector
//   o_grant      : one-hot grant (zero when no request), combinational
//   o_grant_idx  : binary index of the granted requester (0 when none)
//   o_grant_vld  : any grant this cycle
// ---------------------------------------------------------------------------
module bcpu_rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [N-1:0]  i_req,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_grant_idx,
    output logic          o_grant_vld
);

    logic [PW-1:0] r_ptr;
    logic [N-1:0]  w_grant;
    logic [PW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        int idx;
        idx     = 0;
        w_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!w_found && i_req[idx]) begin
                w_found      = 1'b1;
                w_grant[idx] = 1'b1;
                w_idx        = PW'(idx);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (int'(w_idx) == N - 1) ? '0 : w_idx + 1'b1;
        end
    end

    assign o_grant     = w_grant;
    assign o_grant_idx = w_idx;
    assign o_grant_vld = w_found;

endmodule

// File: rtl/bcpu_obus_arbiter.sv
// ---------------------------------------------------------------------------
// bcpu_obus_arbiter
// Shared OBUS output-register bank written by NUM_REQ requesters. One request
// per cycle is granted round-robin; the granted op is applied read-modify-write
// to the addressed register, and the result is reported on the DONE channel
// in the following cycle (same cycle it appears on o_obus_out).
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_req_valid      : per-requester valid            [NUM_REQ]
//   o_req_ready      : per-requester accept, one-hot or zero
//   i_req_op         : per-requester bus_wr_op_t      [NUM_REQ*2]
//   i_req_addr       : per-requester register address [NUM_REQ*ADDR_WIDTH]
//   i_req_data       : per-requester data (WRITE)     [NUM_REQ*DATA_WIDTH]
//   i_req_mask       : per-requester bit mask         [NUM_REQ*DATA_WIDTH]
//   o_done_valid     : one-cycle completion pulse
//   o_done_id        : completed requester index
//   o_done_value     : register value after the update
//   o_obus_out       : flattened bank, reg k at [k*DATA_WIDTH +: DATA_WIDTH]
// ADDR_WIDTH and DATA_WIDTH must not exceed OBUS_ADDR_MAX / OBUS_DATA_MAX.
// ---------------------------------------------------------------------------
module bcpu_obus_arbiter
    import bcpu_defs::*;
#(
    parameter int                    NUM_REQ          = 4,
    parameter int                    ADDR_WIDTH       = 4,
    parameter int                    DATA_WIDTH       = 16,
    parameter logic [DATA_WIDTH-1:0] OBUS_RESET_VALUE = '0,
    localparam int                   IDW              = $clog2(NUM_REQ),
    localparam int                   NREG             = 2 ** ADDR_WIDTH
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic [NUM_REQ*2-1:0]          i_req_op,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_mask,
    output logic                          o_done_valid,
    output logic [IDW-1:0]                o_done_id,
    output logic [DATA_WIDTH-1:0]         o_done_value,
    output logic [NREG*DATA_WIDTH-1:0]    o_obus_out
);

    obus_req_t             w_req [NUM_REQ];
    obus_req_t             w_sel;
    logic [NUM_REQ-1:0]    w_grant;
    logic [IDW-1:0]        w_gidx;
    logic                  w_gvld;
    logic                  w_xfer;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_new;

    logic [DATA_WIDTH-1:0] r_obus [NREG];
    logic                  r_done_valid;
    logic [IDW-1:0]        r_done_id;
    logic [DATA_WIDTH-1:0] r_done_value;

    // Unpack the flattened request buses into per-requester structs.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_req[gi].op   = bus_wr_op_t'(i_req_op[gi*2 +: 2]);
        assign w_req[gi].addr = OBUS_ADDR_MAX'(i_req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH]);
        assign w_req[gi].data = OBUS_DATA_MAX'(i_req_data[gi*DATA_WIDTH +: DATA_WIDTH]);
        assign w_req[gi].mask = OBUS_DATA_MAX'(i_req_mask[gi*DATA_WIDTH +: DATA_WIDTH]);
    end

    bcpu_rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req       (i_req_valid),
        .o_grant     (w_grant),
        .o_grant_idx (w_gidx),
        .o_grant_vld (w_gvld)
    );

    // READY is forced low while reset is asserted so no transfer is implied.
    assign o_req_ready = w_grant & {NUM_REQ{i_rst_n}};
    assign w_xfer      = w_gvld & i_rst_n;

    assign w_sel  = w_req[w_gidx];
    assign w_addr = ADDR_WIDTH'(w_sel.addr);
    assign w_new  = DATA_WIDTH'(obus_apply(w_sel.op,
                                           OBUS_DATA_MAX'(r_obus[w_addr]),
                                           w_sel.data, w_sel.mask));

    // Single write port: an op in the next cycle sees this edge's result
    // directly from the bank, so back-to-back same-address ops need no bypass.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NREG; k++) r_obus[k] <= OBUS_RESET_VALUE;
        end else if (w_xfer) begin
            r_obus[w_addr] <= w_new;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_done_valid <= 1'b0;
            r_done_id    <= '0;
            r_done_value <= '0;
        end else begin
            r_done_valid <= w_xfer;
            if (w_xfer) begin
                r_done_id    <= w_gidx;
                r_done_value <= w_new;
            end
        end
    end

    for (genvar gi = 0; gi < NREG; gi++) begin : g_flat
        assign o_obus_out[gi*DATA_WIDTH +: DATA_WIDTH] = r_obus[gi];
    end

    assign o_done_valid = r_done_valid;
    assign o_done_id    = r_done_id;
    assign o_done_value = r_done_value;

endmodule

// File: tb/tb_bcpu_obus_arbiter.sv
module tb_bcpu_obus_arbiter;
    import bcpu_defs::*;

    localparam int N    = 4;
    localparam int AW   = 4;
    localparam int DW   = 16;
    localparam int NREG = 16;
    localparam logic [DW-1:0] RV = 16'h00F0;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*2-1:0]    req_op;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [N*DW-1:0]   req_mask;
    logic              done_valid;
    logic [1:0]        done_id;
    logic [DW-1:0]     done_value;
    logic [NREG*DW-1:0] obus_out;

    bcpu_obus_arbiter #(
        .NUM_REQ          (N),
        .ADDR_WIDTH       (AW),
        .DATA_WIDTH       (DW),
        .OBUS_RESET_VALUE (RV)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_op     (req_op),
        .i_req_addr   (req_addr),
        .i_req_data   (req_data),
        .i_req_mask   (req_mask),
        .o_done_valid (done_valid),
        .o_done_id    (done_id),
        .o_done_value (done_value),
        .o_obus_out   (obus_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Requester-side stimulus state
    logic       tv [N];
    bus_wr_op_t to [N];
    logic [AW-1:0] ta [N];
    logic [DW-1:0] td [N];
    logic [DW-1:0] tm [N];

    // Reference model
    logic [DW-1:0] m_obus [NREG];
    int            m_ptr;
    logic          m_dv;
    int            m_id;
    logic [DW-1:0] m_val;

    task automatic chk(input string tag, input logic [NREG*DW-1:0] obs,
                       input logic [NREG*DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_apply(input bus_wr_op_t op, input logic [DW-1:0] old,
                                                input logic [DW-1:0] d, input logic [DW-1:0] m);
        case (op)
            OP_WRITE: return (old & ~m) | (d & m);
            OP_SET:   return old | m;
            OP_RESET: return old & ~m;
            default:  return old ^ m;
        endcase
    endfunction

    function automatic int ref_grant();
        for (int k = 0; k < N; k++) begin
            if (tv[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [NREG*DW-1:0] ref_flat();
        logic [NREG*DW-1:0] f;
        for (int k = 0; k < NREG; k++) f[k*DW +: DW] = m_obus[k];
        return f;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NREG; k++) m_obus[k] = RV;
        m_ptr = 0; m_dv = 1'b0; m_id = 0; m_val = '0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = tv[i];
            req_op[i*2 +: 2]       = to[i];
            req_addr[i*AW +: AW]   = ta[i];
            req_data[i*DW +: DW]   = td[i];
            req_mask[i*DW +: DW]   = tm[i];
        end
    endtask

    task automatic set_req(input int i, input bus_wr_op_t op, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] m);
        tv[i] = 1'b1; to[i] = op; ta[i] = a; td[i] = d; tm[i] = m;
    endtask

    // One clock cycle: called just after a falling edge, returns at the next one.
    task automatic cycle(input string tag);
        int g;
        logic [N-1:0] exp_rdy;
        drive();
        #1;
        g = ref_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk({tag, ".ready"}, NREG*DW'(req_ready), NREG*DW'(exp_rdy));
        @(posedge clk);
        #1;
        if (g >= 0) begin
            m_val = ref_apply(to[g], m_obus[ta[g]], td[g], tm[g]);
            m_obus[ta[g]] = m_val;
            m_id  = g;
            m_dv  = 1'b1;
            m_ptr = (g + 1) % N;
            tv[g] = 1'b0;
        end else begin
            m_dv = 1'b0;
        end
        $display("cycle %s: grant=%0d done_valid=%0b id=%0d value=%h", tag, g, done_valid, done_id, done_value);
        chk({tag, ".done_valid"}, NREG*DW'(done_valid), NREG*DW'(m_dv));
        chk({tag, ".done_id"},    NREG*DW'(done_id),    NREG*DW'(m_id));
        chk({tag, ".done_value"}, NREG*DW'(done_value), NREG*DW'(m_val));
        chk({tag, ".obus"},       obus_out,             ref_flat());
        @(negedge clk);
    endtask

    int rr_exp [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            tv[i] = 1'b0; to[i] = OP_WRITE; ta[i] = '0; td[i] = '0; tm[i] = '0;
        end
        drive();
        model_reset();

        // Reset: valid held high must still see READY=0
        for (int i = 0; i < N; i++) set_req(i, OP_SET, AW'(i), '0, 16'hFFFF);
        drive();
        repeat (3) @(negedge clk);
        chk("rst.ready",      NREG*DW'(req_ready),  '0);
        chk("rst.done_valid", NREG*DW'(done_valid), '0);
        chk("rst.done_id",    NREG*DW'(done_id),    '0);
        chk("rst.done_value", NREG*DW'(done_value), '0);
        chk("rst.obus",       obus_out,             ref_flat());
        for (int i = 0; i < N; i++) tv[i] = 1'b0;
        drive();
        rst_n = 1'b1;
        cycle("idle0");
        cycle("idle1");

        // All four ops on address 3
        set_req(0, OP_SET, 4'd3, 16'h0000, 16'h0F00);    cycle("set");
        chk("set.const", NREG*DW'(done_value), NREG*DW'(16'h0FF0));
        set_req(0, OP_RESET, 4'd3, 16'h0000, 16'h00F0);  cycle("reset");
        chk("reset.const", NREG*DW'(done_value), NREG*DW'(16'h0F00));
        set_req(0, OP_INVERT, 4'd3, 16'h0000, 16'hFFFF); cycle("invert");
        chk("invert.const", NREG*DW'(done_value), NREG*DW'(16'hF0FF));
        set_req(0, OP_WRITE, 4'd3, 16'h1234, 16'h00FF);  cycle("write");
        chk("write.const", NREG*DW'(done_value), NREG*DW'(16'hF034));
        chk("write.obus3", NREG*DW'(obus_out[3*DW +: DW]), NREG*DW'(16'hF034));

        // Clear address 0 via requester 3 (pointer then returns to 0)
        set_req(3, OP_WRITE, 4'd0, 16'h0000, 16'hFFFF); cycle("clr0");

        // Round-robin fairness with all four valid
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < N; i++) set_req(i, OP_SET, 4'd0, 16'h0000, DW'(1 << i));
            cycle("rr");
            chk("rr.id.const", NREG*DW'(done_id), NREG*DW'(rr_exp[c]));
            if (c == 3) chk("rr.obus0.const", NREG*DW'(obus_out[DW-1:0]), NREG*DW'(16'h000F));
        end
        for (int i = 0; i < N; i++) tv[i] = 1'b0;

        // Pointer wrap/skip: move pointer to 2, idle, then 0 and 3 valid
        set_req(1, OP_SET, 4'd7, 16'h0000, 16'h8000); cycle("ptr2");
        cycle("idle_hold");
        set_req(0, OP_SET, 4'd8, 16'h0000, 16'h0001);
        set_req(3, OP_SET, 4'd9, 16'h0000, 16'h0002);
        cycle("wrap_a");
        chk("wrap_a.id.const", NREG*DW'(done_id), NREG*DW'(3));
        cycle("wrap_b");
        chk("wrap_b.id.const", NREG*DW'(done_id), NREG*DW'(0));

        // Same-address back-to-back inverts
        set_req(1, OP_INVERT, 4'd5, 16'h0000, 16'h0001); cycle("b2b_a");
        chk("b2b_a.const", NREG*DW'(done_value), NREG*DW'(16'h00F1));
        set_req(1, OP_INVERT, 4'd5, 16'h0000, 16'h0001); cycle("b2b_b");
        chk("b2b_b.const", NREG*DW'(done_value), NREG*DW'(16'h00F0));
        cycle("idle2");

        // Mask=0 still produces a transfer and DONE pulse
        set_req(2, OP_INVERT, 4'd5, 16'h0000, 16'h0000); cycle("mask0");

        // Randomized traffic
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!tv[i] && $urandom_range(0, 2) == 0)
                    set_req(i, bus_wr_op_t'($urandom_range(0, 3)), AW'($urandom_range(0, NREG-1)),
                            DW'($urandom), DW'($urandom));
            end
            cycle("rand");
        end

        // Asynchronous reset between edges with all requests pending
        for (int i = 0; i < N; i++)
            set_req(i, bus_wr_op_t'($urandom_range(0, 3)), AW'($urandom_range(0, NREG-1)),
                    DW'($urandom), DW'($urandom));
        drive();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst.obus",       obus_out,             ref_flat());
        chk("arst.done_valid", NREG*DW'(done_valid), '0);
        chk("arst.ready",      NREG*DW'(req_ready),  '0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle("post_rst0");
        chk("post_rst0.id.const", NREG*DW'(done_id), NREG*DW'(0));
        cycle("post_rst1");
        cycle("post_rst2");
        cycle("post_rst3");
        cycle("post_rst4");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
